div_seq: RTL and testbench

- Multi-cycle divide/remainder sequencer for the EX stage. Replaces the single-cycle "/" and "%" operators for DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW and REMUW.
- Owns an iterative shift-subtract core and drives the EX stall signal (div_not_ready_o) until the result is ready.
- Resolves divide-by-zero and signed overflow on a fast path.
- EX muxes result_o into aluout_o for divide aluops.

---
 rtl/div_seq_pkg.sv | 54 +++++
 rtl/div_seq_if.sv | 24 ++
 rtl/div_core_step.sv | 36 +++
 rtl/div_seq.sv | 152 +++++++++++++++
 tb/tb_div_seq.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared constants and helpers for the sequential divider: ALU op codes,
// FSM state encoding, op decode and iteration count.
package div_seq_pkg;

  // EX aluop codes that the divider acts on; every other code is ignored.
  localparam logic [4:0] AluAdd   = 5'h00;
  localparam logic [4:0] AluDiv   = 5'h10;
  localparam logic [4:0] AluDivu  = 5'h11;
  localparam logic [4:0] AluRem   = 5'h12;
  localparam logic [4:0] AluRemu  = 5'h13;
  localparam logic [4:0] AluDivw  = 5'h14;
  localparam logic [4:0] AluDivuw = 5'h15;
  localparam logic [4:0] AluRemw  = 5'h16;
  localparam logic [4:0] AluRemuw = 5'h17;

  typedef enum logic [1:0] {
    DivsIdle,
    DivsCalc,
    DivsFixup,
    DivsDone
  } divs_state_e;

  typedef struct packed {
    logic is_div;
    logic is_w;
    logic is_signed;
    logic is_rem;
  } div_op_t;

  // Number of iterations for an operand width w at s quotient bits per cycle.
  function automatic int unsigned div_iters(input int unsigned w, input int unsigned s);
    return w / s;
  endfunction

  function automatic div_op_t decode_op(input logic [4:0] aluop);
    div_op_t d;
    d = '0;
    case (aluop)
      AluDiv:   begin d.is_div = 1'b1; d.is_signed = 1'b1;                     end
      AluDivu:  begin d.is_div = 1'b1;                                         end
      AluRem:   begin d.is_div = 1'b1; d.is_signed = 1'b1; d.is_rem = 1'b1;    end
      AluRemu:  begin d.is_div = 1'b1; d.is_rem = 1'b1;                        end
      AluDivw:  begin d.is_div = 1'b1; d.is_w = 1'b1; d.is_signed = 1'b1;      end
      AluDivuw: begin d.is_div = 1'b1; d.is_w = 1'b1;                          end
      AluRemw:  begin
        d.is_div = 1'b1; d.is_w = 1'b1; d.is_signed = 1'b1; d.is_rem = 1'b1;
      end
      AluRemuw: begin d.is_div = 1'b1; d.is_w = 1'b1; d.is_rem = 1'b1;         end
      default:  d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX-stage <-> divider signal bundle. The pipeline side is the master.
interface div_seq_if #(
  parameter int unsigned XLEN = 64
) ();
  logic            valid_i;
  logic [4:0]      aluop_i;
  logic [XLEN-1:0] srcA_i;
  logic [XLEN-1:0] srcB_i;
  logic            flush_i;
  logic            advance_i;
  logic            div_not_ready_o;
  logic            result_valid_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output valid_i, aluop_i, srcA_i, srcB_i, flush_i, advance_i,
    input  div_not_ready_o, result_valid_o, result_o
  );

  modport slave (
    input  valid_i, aluop_i, srcA_i, srcB_i, flush_i, advance_i,
    output div_not_ready_o, result_valid_o, result_o
  );
endinterface

// File: rtl/div_core_step.sv
// Combinational restoring-division step: resolves STEPS quotient bits per call.
// {rem, quo} shift left as one register; quo's MSB feeds rem, quotient bits
// enter quo at the LSB.
module div_core_step #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned STEPS = 1
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] rem;
  logic [XLEN-1:0] quo;

  // STEPS chained shift/trial-subtract stages; diff MSB set means "restore".
  always_comb begin
    rem     = rem_i;
    quo     = quo_i;
    shifted = '0;
    diff    = '0;
    for (int unsigned i = 0; i < STEPS; i++) begin
      shifted = {rem, quo[XLEN-1]};
      diff    = shifted - {1'b0, dvs_i};
      quo     = {quo[XLEN-2:0], ~diff[XLEN]};
      rem     = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end
    rem_o = rem;
    quo_o = quo;
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle divide/remainder sequencer for EX. Stalls EX via div_not_ready_o
// until the result is registered; divide-by-zero and signed overflow bypass
// the iterative core.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned STEPS = 1
) (
  input logic       clock,
  input logic       reset,
  div_seq_if.slave  bus
);

  localparam int unsigned WPad = XLEN - 32;
  localparam int unsigned CntW = $clog2(div_iters(XLEN, STEPS));
  localparam logic [CntW-1:0] ItersFull = CntW'(div_iters(XLEN, STEPS) - 1);
  localparam logic [CntW-1:0] ItersW    = CntW'(div_iters(32, STEPS) - 1);

  divs_state_e     state_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [CntW-1:0] cnt_q;
  logic            sign_quo_q, sign_rem_q, is_rem_q, is_w_q;
  logic [XLEN-1:0] result_q;
  logic            result_valid_q;

  div_op_t         op;
  logic            is_div;
  logic [31:0]     a_w, b_w;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, dvd_init, min_neg;
  logic            s_a, s_b, div_zero, ovf;
  logic [XLEN-1:0] zero_res, ovf_res;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] quo_fix, rem_fix, sel_fix, fix_res;

  // Decode, width-extend operands and detect the fast-path cases.
  always_comb begin
    op     = decode_op(bus.aluop_i);
    is_div = bus.valid_i & op.is_div;
    a_w    = bus.srcA_i[31:0];
    b_w    = bus.srcB_i[31:0];
    a_ext  = bus.srcA_i;
    b_ext  = bus.srcB_i;
    if (op.is_w) begin
      a_ext = op.is_signed ? {{WPad{a_w[31]}}, a_w} : {{WPad{1'b0}}, a_w};
      b_ext = op.is_signed ? {{WPad{b_w[31]}}, b_w} : {{WPad{1'b0}}, b_w};
    end
    s_a   = op.is_signed & a_ext[XLEN-1];
    s_b   = op.is_signed & b_ext[XLEN-1];
    a_mag = s_a ? -a_ext : a_ext;
    b_mag = s_b ? -b_ext : b_ext;
    // W dividends sit at the top of quo so 32 shifts move them fully into rem.
    dvd_init = op.is_w ? (a_mag << WPad) : a_mag;
    min_neg  = op.is_w ? {{(WPad + 1){1'b1}}, 31'b0} : {1'b1, {(XLEN - 1){1'b0}}};
    div_zero = op.is_w ? (b_w == 32'b0) : (bus.srcB_i == '0);
    ovf      = op.is_signed & (a_ext == min_neg) & (b_ext == '1);
    zero_res = op.is_rem ? (op.is_w ? {{WPad{a_w[31]}}, a_w} : bus.srcA_i) : '1;
    ovf_res  = op.is_rem ? '0 : a_ext;
  end

  div_core_step #(
    .XLEN  (XLEN),
    .STEPS (STEPS)
  ) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  // Apply result signs, pick quotient or remainder, sign-extend W results.
  always_comb begin
    quo_fix = sign_quo_q ? -quo_q : quo_q;
    rem_fix = sign_rem_q ? -rem_q : rem_q;
    sel_fix = is_rem_q ? rem_fix : quo_fix;
    fix_res = is_w_q ? {{WPad{sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end

  // Sequencer FSM with registered result outputs; flush overrides every state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= DivsIdle;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      cnt_q          <= '0;
      sign_quo_q     <= 1'b0;
      sign_rem_q     <= 1'b0;
      is_rem_q       <= 1'b0;
      is_w_q         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if (bus.flush_i) begin
      state_q        <= DivsIdle;
      result_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        DivsIdle: begin
          if (is_div) begin
            is_rem_q   <= op.is_rem;
            is_w_q     <= op.is_w;
            sign_quo_q <= s_a ^ s_b;
            sign_rem_q <= s_a;
            if (div_zero) begin
              result_q       <= zero_res;
              result_valid_q <= 1'b1;
              state_q        <= DivsDone;
            end else if (ovf) begin
              result_q       <= ovf_res;
              result_valid_q <= 1'b1;
              state_q        <= DivsDone;
            end else begin
              rem_q   <= '0;
              quo_q   <= dvd_init;
              dvs_q   <= b_mag;
              cnt_q   <= op.is_w ? ItersW : ItersFull;
              state_q <= DivsCalc;
            end
          end
        end
        DivsCalc: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          if (cnt_q == '0) begin
            state_q <= DivsFixup;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        DivsFixup: begin
          result_q       <= fix_res;
          result_valid_q <= 1'b1;
          state_q        <= DivsDone;
        end
        DivsDone: begin
          // Holding here until advance stops a stalled EX from re-issuing.
          if (bus.advance_i) begin
            result_valid_q <= 1'b0;
            state_q        <= DivsIdle;
          end
        end
        default: state_q <= DivsIdle;
      endcase
    end
  end

  assign bus.div_not_ready_o = is_div & (state_q != DivsDone) & ~bus.flush_i;
  assign bus.result_valid_o  = result_valid_q;
  assign bus.result_o        = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed corner cases plus random ops checked
// against an arithmetic reference model.
module tb_div_seq;
  import div_seq_pkg::*;

  logic clock = 1'b0;
  logic reset;

  div_seq_if #(.XLEN(64)) bus ();

  div_seq #(
    .XLEN  (64),
    .STEPS (1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [4:0]  ops[8] = '{AluDiv, AluDivu, AluRem, AluRemu, AluDivw, AluDivuw, AluRemw, AluRemuw};

  function automatic logic [63:0] sext32(input logic [31:0] x);
    return {{32{x[31]}}, x};
  endfunction

  // Reference: RISC-V M-extension divide semantics in plain arithmetic.
  function automatic logic [63:0] ref_result(input logic [4:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    longint sa = $signed(a);
    longint sb = $signed(b);
    logic [31:0] a32 = a[31:0];
    logic [31:0] b32 = b[31:0];
    int sa32 = $signed(a32);
    int sb32 = $signed(b32);
    logic ovf64 = (a == 64'h8000_0000_0000_0000) && (b == '1);
    logic ovf32 = (a32 == 32'h8000_0000) && (b32 == '1);
    logic [31:0] t;
    case (op)
      AluDiv:   return (b == 0) ? '1 : ovf64 ? a : 64'(sa / sb);
      AluDivu:  return (b == 0) ? '1 : a / b;
      AluRem:   return (b == 0) ? a : ovf64 ? 64'd0 : 64'(sa % sb);
      AluRemu:  return (b == 0) ? a : a % b;
      AluDivw: begin
        if (b32 == 0) return '1;
        if (ovf32) return sext32(a32);
        t = 32'(sa32 / sb32);
        return sext32(t);
      end
      AluDivuw: return (b32 == 0) ? '1 : sext32(a32 / b32);
      AluRemw: begin
        if (b32 == 0) return sext32(a32);
        if (ovf32) return 64'd0;
        t = 32'(sa32 % sb32);
        return sext32(t);
      end
      AluRemuw: return (b32 == 0) ? sext32(a32) : sext32(a32 % b32);
      default:  return 64'd0;
    endcase
  endfunction

  // Stall cycles from the divider's latency rules.
  function automatic int exp_stalls(input logic [4:0] op, input logic [63:0] a,
                                    input logic [63:0] b);
    logic w   = op inside {AluDivw, AluDivuw, AluRemw, AluRemuw};
    logic sgn = op inside {AluDiv, AluRem, AluDivw, AluRemw};
    logic zero = w ? (b[31:0] == 0) : (b == 0);
    logic ovf  = sgn && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == '1)
                           : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return w ? 34 : 66;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, req);
    end
  endtask

  // Issue one divide, measure its stall length, optionally hold it in DONE.
  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input int hold);
    int stalls = 0;
    bit done = 0;
    @(posedge clock);
    #1;
    bus.valid_i   = 1'b1;
    bus.aluop_i   = op;
    bus.srcA_i    = a;
    bus.srcB_i    = b;
    bus.advance_i = 1'b0;
    exp_q.push_back(ref_result(op, a, b));
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clock);
      if (bus.result_valid_o) done = 1;
      else if (bus.div_not_ready_o) stalls++;
    end
    check("result_valid_timeout", 64'(done), 64'd1);
    check("stall_cycles", 64'(stalls), 64'(exp_stalls(op, a, b)));
    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      check("hold_valid", 64'(bus.result_valid_o), 64'd1);
      check("hold_not_ready", 64'(bus.div_not_ready_o), 64'd0);
    end
    @(posedge clock);
    #1 bus.advance_i = 1'b1;
    @(posedge clock);
    #1;
    bus.advance_i = 1'b0;
    bus.valid_i   = 1'b0;
    bus.aluop_i   = AluAdd;
  endtask

  // Monitor: compare each newly presented result against the scoreboard head.
  initial begin
    logic rv_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.result_valid_o && !rv_prev) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_result: got 0x%016h expected none", bus.result_o);
        end else begin
          check("result", bus.result_o, exp_q.pop_front());
        end
      end
      rv_prev = bus.result_valid_o;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  op;
    logic [63:0] a, b;
    reset         = 1'b0;
    bus.valid_i   = 1'b0;
    bus.aluop_i   = AluAdd;
    bus.srcA_i    = '0;
    bus.srcB_i    = '0;
    bus.flush_i   = 1'b0;
    bus.advance_i = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_valid", 64'(bus.result_valid_o), 64'd0);
    check("reset_not_ready", 64'(bus.div_not_ready_o), 64'd0);
    reset = 1'b1;

    // Non-divide op must not stall or start anything.
    @(posedge clock);
    #1 bus.valid_i = 1'b1;
    bus.aluop_i = AluAdd;
    @(negedge clock);
    check("nondiv_not_ready", 64'(bus.div_not_ready_o), 64'd0);
    @(negedge clock);
    check("nondiv_valid", 64'(bus.result_valid_o), 64'd0);
    bus.valid_i = 1'b0;

    issue(AluDiv, 64'hffff_ffff_ffff_ffec, 64'd3, 0);
    issue(AluRemuw, 64'h0000_0001_8000_0007, 64'h10, 0);
    issue(AluDivuw, 64'h0000_0001_8000_0007, 64'h10, 0);
    issue(AluDiv, 64'd12345, 64'd0, 0);
    issue(AluRemw, 64'h1_8000_0000, 64'h1_0000_0000, 0);
    issue(AluDiv, 64'h8000_0000_0000_0000, '1, 0);
    issue(AluRem, 64'h8000_0000_0000_0000, '1, 0);
    issue(AluDivw, 64'h8000_0000, 64'hffff_ffff, 0);

    // Flush mid-calculation, then a fresh divide pays full latency.
    @(posedge clock);
    #1 bus.valid_i = 1'b1;
    bus.aluop_i = AluDiv;
    bus.srcA_i  = 64'd1234;
    bus.srcB_i  = 64'd5;
    repeat (10) @(posedge clock);
    #1;
    check("pre_flush_not_ready", 64'(bus.div_not_ready_o), 64'd1);
    bus.flush_i = 1'b1;
    #1;
    check("flush_not_ready", 64'(bus.div_not_ready_o), 64'd0);
    @(posedge clock);
    #1 bus.flush_i = 1'b0;
    bus.valid_i = 1'b0;
    @(negedge clock);
    check("flush_valid", 64'(bus.result_valid_o), 64'd0);
    issue(AluDivu, 64'd100, 64'd7, 0);

    // Held in DONE without advance: result stays, no restart.
    issue(AluRem, 64'hffff_ffff_ffff_ff9c, 64'd7, 5);

    // Asynchronous reset mid-calculation clears outputs immediately.
    @(posedge clock);
    #1 bus.valid_i = 1'b1;
    bus.aluop_i = AluDivu;
    bus.srcA_i  = 64'd999;
    bus.srcB_i  = 64'd4;
    repeat (20) @(posedge clock);
    #1 bus.valid_i = 1'b0;
    reset = 1'b0;
    #1;
    check("async_reset_result", bus.result_o, 64'd0);
    check("async_reset_valid", 64'(bus.result_valid_o), 64'd0);
    check("async_reset_not_ready", 64'(bus.div_not_ready_o), 64'd0);
    #2 reset = 1'b1;

    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(0, 7)];
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = (op inside {AluDivw, AluDivuw, AluRemw, AluRemuw}) ? {$urandom, 32'd0} : '0;
        1: begin
          a = (op inside {AluDivw, AluDivuw, AluRemw, AluRemuw}) ? 64'h8000_0000
                                                                 : 64'h8000_0000_0000_0000;
          b = '1;
        end
        2: begin
          a = 64'($urandom_range(0, 1000)) - 64'd500;
          b = 64'($urandom_range(1, 20)) - 64'd10;
          if (b == 0) b = 64'd3;
        end
        3: b = 64'($urandom);
        default: ;
      endcase
      issue(op, a, b, 0);
    end

    repeat (3) @(negedge clock);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
